// File: rtl/ctrl_pkg.sv
// ctrl_pkg: types and helpers shared by the secant controller and its measurement front end.
package ctrl_pkg;

    typedef enum logic [1:0] {SETTLE, ACQUIRE, DONE} q_sampler_state_t;

    function automatic logic [31:0] full_scale(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// settle_counter: loadable down-counter timing the analog settling interval.
module settle_counter #(
    parameter int unsigned CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Holds the cycles left in SETTLE, including the current one; done marks the last.
    assign done_o = cnt_q == W'(1);

    always_comb cnt_d = start_i ? W'(CYCLES) : (en_i && !done_o) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= W'(CYCLES);
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/q_sampler.sv
// q_sampler: settles after every i_ref change, then averages power-of-two ADC windows
// into q_measured with a one-cycle ready pulse per fresh result.
module q_sampler
    import ctrl_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 10,
    parameter int unsigned ADC_WIDTH     = 10,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned AVG_LOG2      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy,
    output logic                 overrange
);

    localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    q_sampler_state_t     state_q, state_d;
    logic [BUS_WIDTH-1:0] i_ref_q, q_q, q_d, avg_aligned;
    logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADC_WIDTH-1:0] avg;
    logic                 win_ovr_q, win_ovr_d, ovr_q, ovr_d;
    logic                 change, full, settle_done, win_end;

    assign change   = i_ref != i_ref_q;
    assign full     = adc_data == ADC_WIDTH'(full_scale(ADC_WIDTH));
    assign acc_sum  = acc_q + ACC_W'(adc_data);
    assign avg      = ADC_WIDTH'(acc_sum >> AVG_LOG2);
    assign win_end  = state_q == ACQUIRE && adc_valid && cnt_q == LAST;

    // Left-align the average onto the bus: pad LSBs when wider, drop LSBs when narrower.
    if (BUS_WIDTH >= ADC_WIDTH) begin : g_pad
        assign avg_aligned = BUS_WIDTH'(avg) << (BUS_WIDTH - ADC_WIDTH);
    end else begin : g_trunc
        assign avg_aligned = BUS_WIDTH'(avg >> (ADC_WIDTH - BUS_WIDTH));
    end

    settle_counter #(.CYCLES(SETTLE_CYCLES)) u_settle (
        .clk     (clk),
        .rst_n   (rst),
        .start_i (change),
        .en_i    (state_q == SETTLE),
        .done_o  (settle_done)
    );

    // Window state is cleared by default and only carried while acquiring undisturbed.
    always_comb begin
        state_d   = state_q;
        acc_d     = '0;
        cnt_d     = '0;
        win_ovr_d = 1'b0;
        q_d       = q_q;
        ovr_d     = ovr_q;
        if (change) state_d = SETTLE;
        else if (state_q == SETTLE) state_d = settle_done ? ACQUIRE : SETTLE;
        else if (state_q == DONE) state_d = ACQUIRE;
        else begin
            acc_d     = adc_valid ? acc_sum : acc_q;
            cnt_d     = adc_valid ? cnt_q + CNT_W'(1) : cnt_q;
            win_ovr_d = win_ovr_q | (adc_valid & full);
            if (win_end) begin
                state_d = DONE;
                q_d     = avg_aligned;
                ovr_d   = win_ovr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SETTLE;
            i_ref_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            win_ovr_q <= 1'b0;
            q_q       <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_ref_q   <= i_ref;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            win_ovr_q <= win_ovr_d;
            q_q       <= q_d;
            ovr_q     <= ovr_d;
        end
    end

    assign q_measured = q_q;
    assign ready      = state_q == DONE;
    assign busy       = state_q == SETTLE;
    assign overrange  = ovr_q;

endmodule

// File: tb/tb_q_sampler.sv
// tb_q_sampler: directed scenarios for q_sampler with SETTLE_CYCLES=4, AVG_LOG2=2.
module tb_q_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] i_ref = '0;
    logic [9:0] adc_data = '0;
    logic       adc_valid = 1'b0;
    logic [9:0] q_measured;
    logic       ready, busy, overrange;
    int         vectors = 0;
    int         miscompares = 0;

    q_sampler #(.BUS_WIDTH(10), .ADC_WIDTH(10), .SETTLE_CYCLES(4), .AVG_LOG2(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ref      (i_ref),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .q_measured (q_measured),
        .ready      (ready),
        .busy       (busy),
        .overrange  (overrange)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge(s); outputs are sampled and inputs driven there.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset and return 1 ns into cycle 0 after release.
    task automatic restart;
        i_ref = '0;
        adc_valid = 1'b0;
        adc_data = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic feed4(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
        logic [9:0] s [4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            adc_data = s[i];
            step();
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_reset;
        adc_valid = 1'b1;
        adc_data = 10'd100;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1 || ready !== 1'b0 || q_measured !== 10'd0 || overrange !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b ready=%b q=%0d ovr=%b, want 1 0 0 0", busy, ready, q_measured, overrange);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c <= 18; c++) begin
            vectors++;
            if (busy !== (c < 4)) begin
                miscompares++;
                $display("FAIL reset_busy c%0d: got %b want %b", c, busy, c < 4);
            end
            vectors++;
            if (ready !== (c == 8 || c == 13 || c == 18)) begin
                miscompares++;
                $display("FAIL reset_ready c%0d: got %b want %b", c, ready, c == 8 || c == 13 || c == 18);
            end
            if (c == 8) begin
                vectors++;
                if (q_measured !== 10'd100) begin
                    miscompares++;
                    $display("FAIL reset_q c8: got %0d want 100", q_measured);
                end
            end
            step();
        end
    endtask

    task automatic test_average;
        restart();
        step(4);
        feed4(10'd10, 10'd11, 10'd12, 10'd14);
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd11 || overrange !== 1'b0) begin
            miscompares++;
            $display("FAIL average: ready=%b q=%0d ovr=%b, want 1 11 0", ready, q_measured, overrange);
        end
    endtask

    task automatic test_iref_change;
        restart();
        step(4);
        adc_valid = 1'b1;
        adc_data = 10'd200;
        step(2);
        i_ref = 10'd512;
        adc_data = 10'd1023;
        step();
        for (int c = 7; c <= 10; c++) begin
            vectors++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                miscompares++;
                $display("FAIL change_settle c%0d: busy=%b ready=%b, want 1 0", c, busy, ready);
            end
            step();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL change_acquire: busy=%b want 0", busy);
        end
        feed4(10'd40, 10'd41, 10'd42, 10'd43);
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd41 || overrange !== 1'b0) begin
            miscompares++;
            $display("FAIL change_result: ready=%b q=%0d ovr=%b, want 1 41 0", ready, q_measured, overrange);
        end
    endtask

    task automatic test_overrange;
        restart();
        step(4);
        feed4(10'd1023, 10'd0, 10'd0, 10'd1);
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd256 || overrange !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: ready=%b q=%0d ovr=%b, want 1 256 1", ready, q_measured, overrange);
        end
        adc_valid = 1'b1;
        adc_data = 10'd500;
        step(2);
        vectors++;
        if (ready !== 1'b0 || overrange !== 1'b1 || q_measured !== 10'd256) begin
            miscompares++;
            $display("FAIL ovr_hold: ready=%b q=%0d ovr=%b, want 0 256 1", ready, q_measured, overrange);
        end
        step(3);
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd500 || overrange !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: ready=%b q=%0d ovr=%b, want 1 500 0", ready, q_measured, overrange);
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_sparse_valid;
        restart();
        step(4);
        for (int c = 4; c <= 13; c++) begin
            vectors++;
            if (ready !== 1'b0) begin
                miscompares++;
                $display("FAIL sparse_early c%0d: ready=%b want 0", c, ready);
            end
            adc_valid = ((c - 4) % 3) == 0;
            adc_data = adc_valid ? 10'(8 * ((c - 4) / 3 + 1)) : 10'd1023;
            step();
        end
        adc_valid = 1'b0;
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd20 || overrange !== 1'b0) begin
            miscompares++;
            $display("FAIL sparse_result: ready=%b q=%0d ovr=%b, want 1 20 0", ready, q_measured, overrange);
        end
    endtask

    task automatic test_change_boundary;
        restart();
        step(4);
        adc_valid = 1'b1;
        adc_data = 10'd100;
        step(3);
        i_ref = 10'd5;
        step();
        adc_valid = 1'b0;
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1 || q_measured !== 10'd0) begin
            miscompares++;
            $display("FAIL change_at_end: ready=%b busy=%b q=%0d, want 0 1 0", ready, busy, q_measured);
        end
        step(4);
        feed4(10'd100, 10'd100, 10'd100, 10'd100);
        i_ref = 10'd7;
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd100) begin
            miscompares++;
            $display("FAIL change_in_done: ready=%b q=%0d, want 1 100", ready, q_measured);
        end
        step();
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1 || q_measured !== 10'd100) begin
            miscompares++;
            $display("FAIL after_done_change: ready=%b busy=%b q=%0d, want 0 1 100", ready, busy, q_measured);
        end
    endtask

    task automatic test_async_reset;
        restart();
        step(4);
        adc_valid = 1'b1;
        adc_data = 10'd1023;
        step(4);
        vectors++;
        if (ready !== 1'b1 || q_measured !== 10'd1023 || overrange !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: ready=%b q=%0d ovr=%b, want 1 1023 1", ready, q_measured, overrange);
        end
        step(2);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (q_measured !== 10'd0 || ready !== 1'b0 || overrange !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_immediate: q=%0d ready=%b ovr=%b busy=%b, want 0 0 0 1", q_measured, ready, overrange, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c <= 8; c++) begin
            vectors++;
            if (busy !== (c < 4) || ready !== (c == 8)) begin
                miscompares++;
                $display("FAIL arst_restart c%0d: busy=%b ready=%b, want %b %b", c, busy, ready, c < 4, c == 8);
            end
            if (c == 8) begin
                vectors++;
                if (q_measured !== 10'd1023 || overrange !== 1'b1) begin
                    miscompares++;
                    $display("FAIL arst_result: q=%0d ovr=%b, want 1023 1", q_measured, overrange);
                end
            end
            step();
        end
        adc_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_average();
        test_iref_change();
        test_overrange();
        test_sparse_valid();
        test_change_boundary();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/q_sampler.md
# q_sampler

Measurement front end for the secant current-reference controller. Watches `i_ref` as it leaves the controller, waits a programmable analog settling time after every change, averages a power-of-two window of ADC samples into `q_measured`, and pulses `ready` so the controller advances one step per fresh measurement. Re-measures continuously while `i_ref` is stable, so controller steps that do not touch `i_ref` still receive a `ready` pulse.

## Interface
- `BUS_WIDTH`, 10: width of `i_ref` and `q_measured`
- `ADC_WIDTH`, 10: width of raw ADC samples
- `SETTLE_CYCLES`, 64: clock cycles discarded after an `i_ref` change, ≥1
- `AVG_LOG2`, 3: averaging window = 2**AVG_LOG2 valid samples, 0..6
---
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_ref`  in  BUS_WIDTH  current reference driven by the controller
- `adc_data`  in  ADC_WIDTH  raw conversion result
- `adc_valid`  in  1  `adc_data` valid this cycle
- `q_measured`  out  BUS_WIDTH  averaged measurement, registered
- `ready`  out  1  one-cycle pulse, new `q_measured` available
- `busy`  out  1  high while settling
- `overrange`  out  1  window contained a full-scale sample; qualified by `ready`, held until next window result

## Operation
- States: SETTLE, ACQUIRE, DONE. Reset state SETTLE with the counter at 0.
- `i_ref_q` registers `i_ref`; its reset value is 0. Change means `i_ref != i_ref_q`.
- SETTLE: counts SETTLE_CYCLES cycles and ignores `adc_valid`. Then moves to ACQUIRE with the accumulator and sample count cleared.
- ACQUIRE: every `adc_valid` adds `adc_data` into an accumulator of ADC_WIDTH+AVG_LOG2 bits, which cannot overflow. Any sample equal to all-ones sets the window overrange flag.
- Window end: the edge that accepts sample 2**AVG_LOG2 does the following:
  - loads `q_measured` with accumulator >> AVG_LOG2 (truncating), left-aligned to BUS_WIDTH: MSBs kept if wider, zero LSB padding if narrower;
  - loads `overrange` with the window overrange flag;
  - moves to DONE.
- DONE: lasts exactly one cycle with `ready`=1. `adc_valid` is ignored. Returns to ACQUIRE with a cleared accumulator.
- An `i_ref` change in any state forces SETTLE with counter 0 and discards the partial window and its overrange flag.
  - A change in the same cycle as window end wins: no update, and no `ready` on the next cycle.
  - A change during DONE does not cancel the `ready` already asserted.
- `busy` = (state == SETTLE).
- Reset values: `q_measured`=0, `ready`=0, `overrange`=0, `busy`=1.

## Timing
- Change seen in cycle N: SETTLE occupies cycles N+1..N+SETTLE_CYCLES. The first acceptable sample is in cycle N+SETTLE_CYCLES+1.
- After reset deassertion, cycles 0..SETTLE_CYCLES-1 are SETTLE.
- Last window sample in cycle M: `ready` and the new `q_measured` are both visible in cycle M+1.
- With `adc_valid` held high and `i_ref` stable, the `ready` period is 2**AVG_LOG2+1 cycles.
- Reset assertion clears all state and outputs immediately, with no clock edge needed. Operation restarts from SETTLE on deassertion.

## Structure
- Shared `ctrl_pkg`: `q_sampler_state_t` enum (SETTLE, ACQUIRE, DONE) and the full-scale constant helper. The secant controller imports the same package.
- One sub-module, `settle_counter`: a loadable down-counter with `start`, `done`, and width $clog2(SETTLE_CYCLES+1).
- Accumulator, overrange flag, and FSM stay in `q_sampler`.

## Test plan
All scenarios use SETTLE_CYCLES=4 and AVG_LOG2=2 unless stated.
- Reset release, `i_ref` constant, `adc_valid`=1, `adc_data`=100:
  - `busy`=1 in cycles 0-3;
  - `ready` in cycle 8 with `q_measured`=100;
  - further `ready` pulses in cycles 13 and 18.
- Samples 10, 11, 12, 14: `q_measured`=11 (47>>2 truncated).
- `i_ref` changes from 0 to 512 after 2 accepted samples:
  - the partial window is discarded and `busy` is high for 4 cycles;
  - the next `ready` comes only after 4 fresh samples and reflects only those samples.
- Window containing sample 1023: `overrange`=1 at that `ready`. Next window all 500: `overrange`=0, `q_measured`=500.
- `adc_valid` high every third cycle: `ready` only after the 4th valid sample. Invalid-cycle `adc_data`=1023 must not affect the result.
- `rst` low mid-ACQUIRE, asynchronous to `clk`: `q_measured`, `ready`, `overrange` go to 0 and `busy` to 1 before the next edge; full settle-plus-window sequence on release.
